// File: rtl/geofence_pattern_driver_if.sv
// Host/engine-facing signal bundle of the geofence pattern driver.
// master = the pattern driver itself; slave = host and engine side.
interface geofence_pattern_driver_if;
  logic       ld_en;
  logic [9:0] ld_x;
  logic [9:0] ld_y;
  logic       ld_exp;
  logic       start;
  logic [9:0] X;
  logic [9:0] Y;
  logic       valid;
  logic       is_inside;
  logic       busy;
  logic       done;
  logic [4:0] obj_cnt;
  logic [4:0] err_cnt;
  logic       timeout;
  logic       spurious;

  modport master (
    input  ld_en, ld_x, ld_y, ld_exp, start, valid, is_inside,
    output X, Y, busy, done, obj_cnt, err_cnt, timeout, spurious
  );

  modport slave (
    output ld_en, ld_x, ld_y, ld_exp, start, valid, is_inside,
    input  X, Y, busy, done, obj_cnt, err_cnt, timeout, spurious
  );
endinterface

// File: rtl/geofence_pattern_driver.sv
// Streams buffered geofence objects (target + 6 vertices) to the engine and
// scores each valid/is_inside reply against the stored expected bit.
module geofence_pattern_driver #(
  parameter int MAX_OBJ = 16,
  parameter int TIMEOUT = 1023
) (
  input logic                        clk,
  input logic                        reset,
  geofence_pattern_driver_if.master  bus
);
  localparam int PTS    = MAX_OBJ * 7;
  localparam int PTR_W  = $clog2(PTS + 1);
  localparam int WAIT_W = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);
  localparam logic [4:0]        TOTAL_MAX = 5'(MAX_OBJ);

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_WAIT, S_DONE} state_t;

  state_t             state_q, state_d;
  logic [19:0]        pts_mem [1 << PTR_W];
  logic               exp_mem [32];
  logic [PTR_W-1:0]   ld_ptr_q, ld_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [2:0]         ld_idx_q, ld_idx_d;
  logic [2:0]         snd_idx_q, snd_idx_d;
  logic [4:0]         total_q, total_d;
  logic [4:0]         obj_cnt_q, obj_cnt_d;
  logic [4:0]         err_cnt_q, err_cnt_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic [9:0]         x_q, x_d, y_q, y_d;
  logic               busy_q, busy_d, done_q, done_d;
  logic               timeout_q, timeout_d, spurious_q, spurious_d;
  logic               pt_we, exp_we;
  logic [19:0]        rd_pt;
  logic               last_obj;

  assign rd_pt    = pts_mem[rd_ptr_q];
  assign last_obj = (obj_cnt_q + 5'd1) == total_q;

  always_comb begin
    state_d    = state_q;
    ld_ptr_d   = ld_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    ld_idx_d   = ld_idx_q;
    snd_idx_d  = snd_idx_q;
    total_d    = total_q;
    obj_cnt_d  = obj_cnt_q;
    err_cnt_d  = err_cnt_q;
    wait_d     = wait_q;
    x_d        = x_q;
    y_d        = y_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    timeout_d  = timeout_q;
    spurious_d = spurious_q;
    pt_we      = 1'b0;
    exp_we     = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (bus.ld_en && total_q != TOTAL_MAX) begin
          pt_we    = 1'b1;
          ld_ptr_d = ld_ptr_q + PTR_W'(1);
          if (ld_idx_q == 3'd6) begin
            exp_we   = 1'b1;
            ld_idx_d = 3'd0;
            total_d  = total_q + 5'd1;
          end else begin
            ld_idx_d = ld_idx_q + 3'd1;
          end
        end
        if (bus.start) begin
          obj_cnt_d  = 5'd0;
          err_cnt_d  = 5'd0;
          timeout_d  = 1'b0;
          spurious_d = 1'b0;
          if (total_q != 5'd0) begin
            state_d   = S_SEND;
            busy_d    = 1'b1;
            x_d       = pts_mem[0][19:10];
            y_d       = pts_mem[0][9:0];
            rd_ptr_d  = PTR_W'(1);
            snd_idx_d = 3'd0;
          end else begin
            state_d = S_DONE;
            done_d  = 1'b1;
          end
        end
      end

      S_SEND: begin
        if (snd_idx_q == 3'd6) begin
          x_d     = 10'd0;
          y_d     = 10'd0;
          wait_d  = '0;
          state_d = S_WAIT;
        end else begin
          x_d       = rd_pt[19:10];
          y_d       = rd_pt[9:0];
          rd_ptr_d  = rd_ptr_q + PTR_W'(1);
          snd_idx_d = snd_idx_q + 3'd1;
        end
      end

      S_WAIT: begin
        if (bus.valid) begin
          obj_cnt_d = obj_cnt_q + 5'd1;
          if (bus.is_inside != exp_mem[obj_cnt_q] && err_cnt_q != 5'd31)
            err_cnt_d = err_cnt_q + 5'd1;
          if (last_obj) begin
            state_d = S_DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            // Next target goes out the very next cycle; the engine expects it there.
            state_d   = S_SEND;
            snd_idx_d = 3'd0;
            x_d       = rd_pt[19:10];
            y_d       = rd_pt[9:0];
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
          end
        end else if (wait_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_DONE;
          busy_d    = 1'b0;
          done_d    = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    if (bus.valid && state_q != S_WAIT)
      spurious_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      ld_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ld_idx_q   <= 3'd0;
      snd_idx_q  <= 3'd0;
      total_q    <= 5'd0;
      obj_cnt_q  <= 5'd0;
      err_cnt_q  <= 5'd0;
      wait_q     <= '0;
      x_q        <= 10'd0;
      y_q        <= 10'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      timeout_q  <= 1'b0;
      spurious_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ld_ptr_q   <= ld_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ld_idx_q   <= ld_idx_d;
      snd_idx_q  <= snd_idx_d;
      total_q    <= total_d;
      obj_cnt_q  <= obj_cnt_d;
      err_cnt_q  <= err_cnt_d;
      wait_q     <= wait_d;
      x_q        <= x_d;
      y_q        <= y_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      timeout_q  <= timeout_d;
      spurious_q <= spurious_d;
    end
  end

  // Buffer contents survive reset; only the pointers are cleared.
  always_ff @(posedge clk) begin
    if (pt_we)  pts_mem[ld_ptr_q] <= {bus.ld_x, bus.ld_y};
    if (exp_we) exp_mem[total_q]  <= bus.ld_exp;
  end

  assign bus.X        = x_q;
  assign bus.Y        = y_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.obj_cnt  = obj_cnt_q;
  assign bus.err_cnt  = err_cnt_q;
  assign bus.timeout  = timeout_q;
  assign bus.spurious = spurious_q;
endmodule

// File: tb/tb_geofence_pattern_driver.sv
// Directed bench for geofence_pattern_driver: load, stream, score, timeout, limits.
module tb_geofence_pattern_driver;
  logic clk;
  logic reset;
  geofence_pattern_driver_if bus();

  geofence_pattern_driver #(.MAX_OBJ(16), .TIMEOUT(1023)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int vec_cnt     = 0;
  int miscompares = 0;

  logic [9:0] tx [0:127];
  logic [9:0] ty [0:127];
  logic       texp [0:31];
  int         nobj;
  int         lat_a [0:31];
  logic       ans_a [0:31];
  int         spur_at;
  bit         inj;
  int         dx [0:6] = '{0, -3, 0, 3, 3, 0, -3};
  int         dy [0:6] = '{0, -2, -4, -2, 2, 4, 2};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.ld_en = 1'b0; bus.start = 1'b0; bus.valid = 1'b0; bus.is_inside = 1'b0;
    tick(); tick();
    reset = 1'b0;
    nobj = 0;
    spur_at = -1;
    inj = 1'b0;
  endtask

  // The model keeps only the first 16 complete objects.
  task automatic load_obj(input int bx, input int by, input logic e);
    for (int k = 0; k < 7; k++) begin
      bus.ld_en  = 1'b1;
      bus.ld_x   = 10'(bx + dx[k]);
      bus.ld_y   = 10'(by + dy[k]);
      bus.ld_exp = (k == 6) ? e : ~e;
      if (nobj < 16) begin
        tx[nobj*7+k] = 10'(bx + dx[k]);
        ty[nobj*7+k] = 10'(by + dy[k]);
      end
      tick();
    end
    bus.ld_en = 1'b0;
    if (nobj < 16) begin
      texp[nobj] = e;
      nobj++;
    end
  endtask

  task automatic run_and_check(input int n, input int exp_err, input string tag);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int o = 0; o < n; o++) begin
      for (int k = 0; k < 7; k++) begin
        vec_cnt++;
        if ({bus.X, bus.Y, bus.busy} !== {tx[o*7+k], ty[o*7+k], 1'b1}) begin
          miscompares++;
          $display("FAIL %s_point obj%0d pt%0d: got X=%0d Y=%0d busy=%b, expected X=%0d Y=%0d busy=1",
                   tag, o, k, bus.X, bus.Y, bus.busy, tx[o*7+k], ty[o*7+k]);
        end
        if (inj && o == 0) begin
          bus.ld_en = 1'b1; bus.ld_x = 10'h3FF; bus.ld_y = 10'h155; bus.ld_exp = 1'b1;
          bus.start = (k == 2);
        end
        if (o == 0 && k == spur_at) bus.valid = 1'b1;
        tick();
        bus.valid = 1'b0; bus.ld_en = 1'b0; bus.start = 1'b0;
      end
      vec_cnt++;
      if ({bus.X, bus.Y} !== 20'd0) begin
        miscompares++;
        $display("FAIL %s_wait_xy obj%0d: got X=%0d Y=%0d, expected 0 0", tag, o, bus.X, bus.Y);
      end
      repeat (lat_a[o]) tick();
      bus.valid = 1'b1; bus.is_inside = ans_a[o];
      tick();
      bus.valid = 1'b0; bus.is_inside = 1'b0;
    end
    vec_cnt++;
    if ({bus.done, bus.busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL %s_done: got done=%b busy=%b, expected done=1 busy=0", tag, bus.done, bus.busy);
    end
    vec_cnt++;
    if (bus.obj_cnt !== 5'(n) || bus.err_cnt !== 5'(exp_err)) begin
      miscompares++;
      $display("FAIL %s_counts: got obj_cnt=%0d err_cnt=%0d, expected %0d %0d",
               tag, bus.obj_cnt, bus.err_cnt, n, exp_err);
    end
    tick();
    vec_cnt++;
    if (bus.done !== 1'b0) begin
      miscompares++;
      $display("FAIL %s_done_pulse: got done=%b one cycle later, expected 0", tag, bus.done);
    end
  endtask

  task automatic test_reset();
    do_reset();
    vec_cnt++;
    if ({bus.X, bus.Y} !== 20'd0) begin
      miscompares++;
      $display("FAIL reset_xy: got X=%0d Y=%0d, expected 0 0", bus.X, bus.Y);
    end
    vec_cnt++;
    if ({bus.busy, bus.done, bus.timeout, bus.spurious} !== 4'b0000) begin
      miscompares++;
      $display("FAIL reset_flags: got busy/done/timeout/spurious=%b%b%b%b, expected 0000",
               bus.busy, bus.done, bus.timeout, bus.spurious);
    end
    vec_cnt++;
    if (bus.obj_cnt !== 5'd0 || bus.err_cnt !== 5'd0) begin
      miscompares++;
      $display("FAIL reset_counts: got obj_cnt=%0d err_cnt=%0d, expected 0 0", bus.obj_cnt, bus.err_cnt);
    end
  endtask

  task automatic test_single();
    do_reset();
    load_obj(5, 5, 1'b1);
    lat_a[0] = 40; ans_a[0] = 1'b1;
    run_and_check(1, 0, "single");
  endtask

  task automatic test_back_to_back();
    do_reset();
    load_obj(100, 200, 1'b1);
    load_obj(300, 50, 1'b0);
    load_obj(700, 900, 1'b1);
    for (int i = 0; i < 3; i++) begin
      lat_a[i] = (i == 1) ? 0 : 3 + i;
      ans_a[i] = 1'b1;
    end
    run_and_check(3, 1, "b2b");
  endtask

  task automatic test_timeout();
    int cnt;
    do_reset();
    load_obj(20, 30, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (7) tick();
    cnt = 1;
    while (bus.done !== 1'b1 && cnt < 1100) begin
      tick();
      cnt++;
    end
    vec_cnt++;
    if (cnt !== 1024) begin
      miscompares++;
      $display("FAIL timeout_latency: done came %0d cycles after last vertex, expected 1024", cnt);
    end
    vec_cnt++;
    if ({bus.timeout, bus.busy, bus.obj_cnt} !== {1'b1, 1'b0, 5'd0}) begin
      miscompares++;
      $display("FAIL timeout_state: got timeout=%b busy=%b obj_cnt=%0d, expected 1 0 0",
               bus.timeout, bus.busy, bus.obj_cnt);
    end
  endtask

  task automatic test_limits();
    do_reset();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    vec_cnt++;
    if ({bus.done, bus.busy, bus.obj_cnt} !== {1'b1, 1'b0, 5'd0}) begin
      miscompares++;
      $display("FAIL empty_start: got done=%b busy=%b obj_cnt=%0d, expected 1 0 0",
               bus.done, bus.busy, bus.obj_cnt);
    end
    tick();
    vec_cnt++;
    if ({bus.done, bus.busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL empty_after: got done=%b busy=%b, expected 0 0", bus.done, bus.busy);
    end
    for (int i = 0; i < 17; i++) load_obj(10 + i*40, 600 - i*30, 1'(i % 2));
    for (int i = 0; i < 16; i++) begin
      lat_a[i] = 1;
      ans_a[i] = texp[i];
    end
    run_and_check(16, 0, "max_obj");
  endtask

  task automatic test_spurious_and_reset();
    int dcount;
    do_reset();
    load_obj(400, 400, 1'b1);
    load_obj(410, 420, 1'b1);
    lat_a[0] = 2; lat_a[1] = 2; ans_a[0] = 1'b1; ans_a[1] = 1'b1;
    spur_at = 3;
    run_and_check(2, 0, "spurious");
    spur_at = -1;
    vec_cnt++;
    if ({bus.spurious, bus.timeout} !== 2'b10) begin
      miscompares++;
      $display("FAIL spurious_flag: got spurious=%b timeout=%b, expected 1 0", bus.spurious, bus.timeout);
    end

    do_reset();
    load_obj(60, 70, 1'b0);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    repeat (12) tick();
    reset = 1'b1;
    tick();
    vec_cnt++;
    if ({bus.X, bus.Y, bus.busy, bus.done, bus.obj_cnt, bus.err_cnt, bus.timeout, bus.spurious}
        !== 34'd0) begin
      miscompares++;
      $display("FAIL midrun_reset: got X=%0d Y=%0d busy=%b done=%b obj=%0d err=%0d to=%b sp=%b, expected all 0",
               bus.X, bus.Y, bus.busy, bus.done, bus.obj_cnt, bus.err_cnt, bus.timeout, bus.spurious);
    end
    reset = 1'b0;
    dcount = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus.done === 1'b1) dcount++;
    end
    vec_cnt++;
    if (dcount !== 0) begin
      miscompares++;
      $display("FAIL midrun_no_done: got %0d done pulses after reset, expected 0", dcount);
    end
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    vec_cnt++;
    if ({bus.done, bus.busy} !== 2'b10) begin
      miscompares++;
      $display("FAIL reset_total_clear: got done=%b busy=%b, expected 1 0", bus.done, bus.busy);
    end
  endtask

  task automatic test_ignore_during_run();
    do_reset();
    load_obj(250, 260, 1'b1);
    load_obj(500, 510, 1'b0);
    lat_a[0] = 4; lat_a[1] = 6; ans_a[0] = 1'b0; ans_a[1] = 1'b0;
    inj = 1'b1;
    run_and_check(2, 1, "ignore_run1");
    inj = 1'b0;
    ans_a[0] = 1'b1;
    run_and_check(2, 0, "ignore_run2");
    load_obj(800, 810, 1'b1);
    lat_a[2] = 2; ans_a[2] = 1'b1;
    run_and_check(3, 0, "ignore_run3");
  endtask

  initial begin
    reset = 1'b1;
    bus.ld_en = 1'b0; bus.ld_x = '0; bus.ld_y = '0; bus.ld_exp = 1'b0;
    bus.start = 1'b0; bus.valid = 1'b0; bus.is_inside = 1'b0;
    nobj = 0; spur_at = -1; inj = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_timeout();
    test_limits();
    test_spurious_and_reset();
    test_ignore_during_run();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompares);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end
endmodule
